instruction_fetch_unit: RTL and testbench

//  Requesting (initiator) side of the byte-addressed, big-endian instruction memory port.

---
 rtl/instruction_fetch_unit_pkg.sv | 20 ++
 rtl/instruction_fetch_unit_fetch_fifo.sv | 61 ++++++
 rtl/instruction_fetch_unit.sv | 168 ++++++++++++++++
 tb/tb_instruction_fetch_unit.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/instruction_fetch_unit_pkg.sv
// Shared constants, state encoding and sizing helper for the instruction fetch unit.
package instruction_fetch_unit_pkg;

    localparam int          INSTRUCTION_LEN = 32;
    localparam int          IFU_ADDR_W      = 32;
    localparam int          IFU_FIFO_DEPTH  = 2;
    localparam logic [31:0] IFU_RESET_PC    = 32'h0000_0000;

    // IDLE: no request on the bus. REQ: mem_read asserted at the fetch PC.
    typedef enum logic {
        IFU_IDLE = 1'b0,
        IFU_REQ  = 1'b1
    } ifu_state_e;

    // Occupancy counter width: must represent 0..depth inclusive.
    function automatic int ifu_cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_fetch_fifo.sv
// Fetch buffer: small synchronous FIFO of {instr, pc+4} entries.
// Flush empties the buffer and takes priority over a push in the same cycle.
module instruction_fetch_unit_fetch_fifo
    import instruction_fetch_unit_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        push,
    input  logic                        pop,
    input  logic                        flush,
    input  logic [WIDTH-1:0]            din,
    output logic [WIDTH-1:0]            dout,
    output logic [ifu_cnt_w(DEPTH)-1:0] count
);

    localparam int                PTR_W  = $clog2(DEPTH);
    localparam int                CNT_W  = ifu_cnt_w(DEPTH);
    localparam logic [CNT_W-1:0]  FULL_C = CNT_W'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_pop;
    logic             w_do_push;

    // Never pop an empty buffer; a push into a full buffer needs a same-cycle pop.
    assign w_do_pop  = pop & (r_count != '0);
    assign w_do_push = push & ((r_count != FULL_C) | w_do_pop);

    // Entry storage, written at the tail; contents are don't-care until pushed.
    always_ff @(posedge clk) begin
        if (w_do_push && !flush) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointer and occupancy bookkeeping; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
        end
    end

    assign dout  = r_mem[r_rd_ptr];
    assign count = r_count;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: drives word reads to instruction memory, buffers the
// returned words and presents {instr, pc+4} to IF/ID. Handles decode freeze and
// EX branch redirect, including dropping a read that was in flight at the redirect.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter int                INSTR_W    = INSTRUCTION_LEN,
    parameter int                ADDR_W     = IFU_ADDR_W,
    parameter int                FIFO_DEPTH = IFU_FIFO_DEPTH,
    parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(IFU_RESET_PC)
) (
    input  logic               clk,
    input  logic               rst,
    output logic               mem_read,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic               mem_ready,
    input  logic [INSTR_W-1:0] mem_rdata,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_addr,
    input  logic               freeze,
    output logic               if_valid,
    output logic [INSTR_W-1:0] if_instr,
    output logic [ADDR_W-1:0]  if_pc
);

    localparam int                 CNT_W      = ifu_cnt_w(FIFO_DEPTH);
    localparam int                 ENTRY_W    = INSTR_W + ADDR_W;
    localparam logic [CNT_W-1:0]   DEPTH_C    = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]   ONE_C      = CNT_W'(1);
    localparam logic [ADDR_W-1:0]  WORD_STEP  = ADDR_W'(4);
    localparam logic [ADDR_W-1:0]  ALIGN_MASK = ~ADDR_W'(3);

    ifu_state_e          r_state;
    ifu_state_e          w_state_next;
    logic [ADDR_W-1:0]   r_fetch_pc;
    logic [ADDR_W-1:0]   r_redirect_pc;
    logic                r_squash;
    logic [ENTRY_W-1:0]  r_hold;

    logic                w_req;
    logic                w_complete;
    logic                w_outstanding;
    logic                w_push;
    logic                w_pop;
    logic                w_if_valid;
    logic [ADDR_W-1:0]   w_target;
    logic [ENTRY_W-1:0]  w_fifo_din;
    logic [ENTRY_W-1:0]  w_fifo_dout;
    logic [ENTRY_W-1:0]  w_head;
    logic [CNT_W-1:0]    w_fifo_count;
    logic [CNT_W-1:0]    w_next_count;

    assign w_req         = (r_state == IFU_REQ);
    assign w_complete    = w_req & mem_ready;
    assign w_outstanding = w_req & ~mem_ready;
    assign w_if_valid    = (w_fifo_count != '0);
    // A redirect flushes the buffer, so neither the pop nor a response that cycle counts.
    assign w_pop         = w_if_valid & ~freeze & ~branch_taken;
    assign w_push        = w_complete & ~r_squash & ~branch_taken;
    assign w_target      = branch_addr & ALIGN_MASK;
    assign w_fifo_din    = {mem_rdata, r_fetch_pc + WORD_STEP};

    instruction_fetch_unit_fetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fetch_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .flush (branch_taken),
        .din   (w_fifo_din),
        .dout  (w_fifo_dout),
        .count (w_fifo_count)
    );

    // Occupancy after this cycle's push/pop/flush; decides whether a slot is free to request into.
    always_comb begin
        w_next_count = w_fifo_count;
        if (branch_taken) begin
            w_next_count = '0;
        end else begin
            if (w_push) begin
                w_next_count = w_next_count + ONE_C;
            end
            if (w_pop) begin
                w_next_count = w_next_count - ONE_C;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IFU_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state: request while a slot is free; an unanswered request is held.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IFU_IDLE: begin
                if (w_next_count < DEPTH_C) begin
                    w_state_next = IFU_REQ;
                end
            end
            IFU_REQ: begin
                if (mem_ready && (w_next_count >= DEPTH_C)) begin
                    w_state_next = IFU_IDLE;
                end
            end
            default: w_state_next = IFU_IDLE;
        endcase
    end

    // FSM outputs: the address bus is parked at zero whenever no request is issued.
    always_comb begin
        mem_read = 1'b0;
        mem_addr = '0;
        if (r_state == IFU_REQ) begin
            mem_read = 1'b1;
            mem_addr = r_fetch_pc;
        end
    end

    // Fetch PC and squash tracking. While a read is outstanding the bus address must
    // stay put, so a redirect is parked in r_redirect_pc until the response arrives.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc    <= RESET_PC;
            r_redirect_pc <= RESET_PC;
            r_squash      <= 1'b0;
        end else if (branch_taken) begin
            if (w_outstanding) begin
                r_squash      <= 1'b1;
                r_redirect_pc <= w_target;
            end else begin
                r_fetch_pc <= w_target;
                r_squash   <= 1'b0;
            end
        end else if (w_complete) begin
            if (r_squash) begin
                r_fetch_pc <= r_redirect_pc;
                r_squash   <= 1'b0;
            end else begin
                r_fetch_pc <= r_fetch_pc + WORD_STEP;
            end
        end
    end

    // Last presented head entry, so if_instr/if_pc hold their values while the buffer is empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold <= '0;
        end else if (w_if_valid) begin
            r_hold <= w_fifo_dout;
        end
    end

    assign w_head   = w_if_valid ? w_fifo_dout : r_hold;
    assign if_valid = w_if_valid;
    assign if_instr = w_head[ENTRY_W-1:ADDR_W];
    assign if_pc    = w_head[ADDR_W-1:0];

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: table of per-cycle vectors plus
// hand-written sequences for stalled reads, reset and PC wrap.
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic        freeze;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    instruction_fetch_unit #(
        .INSTR_W    (32),
        .ADDR_W     (32),
        .FIFO_DEPTH (2),
        .RESET_PC   (32'h0000_0000)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_read     (mem_read),
        .mem_addr     (mem_addr),
        .mem_ready    (mem_ready),
        .mem_rdata    (mem_rdata),
        .branch_taken (branch_taken),
        .branch_addr  (branch_addr),
        .freeze       (freeze),
        .if_valid     (if_valid),
        .if_instr     (if_instr),
        .if_pc        (if_pc)
    );

    // Memory image: 0xE3A00014 at byte address 4, elsewhere C0DE in the upper half
    // and the low 16 address bits in the lower half.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_0004) return 32'hE3A0_0014;
        return {16'hC0DE, a[15:0]};
    endfunction

    always_comb mem_rdata = mem_word(mem_addr);

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        br;
        logic [31:0] baddr;
        logic        frz;
        logic        e_rd;
        logic [31:0] e_addr;
        logic        e_vld;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
    } vec_t;

    vec_t vecs[19];

    function automatic vec_t mk(input logic r, input logic rdy, input logic br,
                                input logic [31:0] ba, input logic frz,
                                input logic erd, input logic [31:0] ea,
                                input logic ev, input logic [31:0] ei,
                                input logic [31:0] ep);
        vec_t v;
        v.rst = r; v.rdy = rdy; v.br = br; v.baddr = ba; v.frz = frz;
        v.e_rd = erd; v.e_addr = ea; v.e_vld = ev; v.e_instr = ei; v.e_pc = ep;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, clock it, and settle just past the edge.
    task automatic step(input logic r, input logic rdy, input logic br,
                        input logic [31:0] ba, input logic frz);
        rst          = r;
        mem_ready    = rdy;
        branch_taken = br;
        branch_addr  = ba;
        freeze       = frz;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_all(input string tag, input logic erd, input logic [31:0] ea,
                              input logic ev, input logic [31:0] ei, input logic [31:0] ep);
        chk({tag, ".mem_read"}, {31'b0, mem_read}, {31'b0, erd});
        chk({tag, ".mem_addr"}, mem_addr, ea);
        chk({tag, ".if_valid"}, {31'b0, if_valid}, {31'b0, ev});
        chk({tag, ".if_instr"}, if_instr, ei);
        chk({tag, ".if_pc"}, if_pc, ep);
    endtask

    initial begin
        rst = 1'b1; mem_ready = 1'b1; branch_taken = 1'b0; branch_addr = '0; freeze = 1'b0;

        //                rst   rdy   br    baddr        frz  | rd    addr         vld   instr         pc
        vecs[0]  = mk(1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   1'b0, 32'h0,        32'h0);
        vecs[1]  = mk(1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 1'b1, 32'h0,   1'b0, 32'h0,        32'h0);
        vecs[2]  = mk(1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 1'b1, 32'h4,   1'b1, 32'hC0DE0000, 32'h4);
        vecs[3]  = mk(1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 1'b1, 32'h8,   1'b1, 32'hE3A00014, 32'h8);
        vecs[4]  = mk(1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 1'b1, 32'hC,   1'b1, 32'hC0DE0008, 32'hC);
        vecs[5]  = mk(1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   1'b1, 32'hC0DE0008, 32'hC);
        vecs[6]  = mk(1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   1'b1, 32'hC0DE0008, 32'hC);
        vecs[7]  = mk(1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   1'b1, 32'hC0DE0008, 32'hC);
        vecs[8]  = mk(1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   1'b1, 32'hC0DE0008, 32'hC);
        vecs[9]  = mk(1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   1'b1, 32'hC0DE0008, 32'hC);
        vecs[10] = mk(1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 1'b1, 32'h10,  1'b1, 32'hC0DE000C, 32'h10);
        vecs[11] = mk(1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 1'b1, 32'h14,  1'b1, 32'hC0DE0010, 32'h14);
        vecs[12] = mk(1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 1'b1, 32'h18,  1'b1, 32'hC0DE0014, 32'h18);
        vecs[13] = mk(1'b0, 1'b1, 1'b1, 32'h9A,  1'b0, 1'b1, 32'h98,  1'b0, 32'hC0DE0014, 32'h18);
        vecs[14] = mk(1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 1'b1, 32'h9C,  1'b1, 32'hC0DE0098, 32'h9C);
        vecs[15] = mk(1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 1'b1, 32'hA0,  1'b1, 32'hC0DE009C, 32'hA0);
        vecs[16] = mk(1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   1'b1, 32'hC0DE009C, 32'hA0);
        vecs[17] = mk(1'b0, 1'b1, 1'b1, 32'h200, 1'b1, 1'b1, 32'h200, 1'b0, 32'hC0DE009C, 32'hA0);
        vecs[18] = mk(1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 1'b1, 32'h204, 1'b1, 32'hC0DE0200, 32'h204);

        for (int i = 0; i < 19; i++) begin
            step(vecs[i].rst, vecs[i].rdy, vecs[i].br, vecs[i].baddr, vecs[i].frz);
            expect_all($sformatf("v%0d", i), vecs[i].e_rd, vecs[i].e_addr,
                       vecs[i].e_vld, vecs[i].e_instr, vecs[i].e_pc);
        end

        // Stalled read with two redirects during the wait: address held, last target wins.
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        expect_all("stall0", 1'b1, 32'h204, 1'b0, 32'hC0DE0200, 32'h204);
        step(1'b0, 1'b0, 1'b1, 32'h80, 1'b0);
        expect_all("stall1", 1'b1, 32'h204, 1'b0, 32'hC0DE0200, 32'h204);
        step(1'b0, 1'b0, 1'b1, 32'h40, 1'b0);
        expect_all("stall2", 1'b1, 32'h204, 1'b0, 32'hC0DE0200, 32'h204);
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        expect_all("squash_drop", 1'b1, 32'h40, 1'b0, 32'hC0DE0200, 32'h204);
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        expect_all("redirect_head", 1'b1, 32'h44, 1'b1, 32'hC0DE0040, 32'h44);

        // Fill, then reset mid-request with a branch also asserted: reset wins.
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        expect_all("fill", 1'b0, 32'h0, 1'b1, 32'hC0DE0040, 32'h44);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        expect_all("refill_req", 1'b1, 32'h48, 1'b1, 32'hC0DE0044, 32'h48);
        step(1'b1, 1'b0, 1'b1, 32'h300, 1'b0);
        expect_all("mid_reset", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        expect_all("restart_req", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        expect_all("restart_head", 1'b1, 32'h4, 1'b1, 32'hC0DE0000, 32'h4);

        // Redirect to the top word (low bits ignored) and wrap through zero.
        step(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0);
        expect_all("wrap_req", 1'b1, 32'hFFFF_FFFC, 1'b0, 32'hC0DE0000, 32'h4);
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        expect_all("wrap_head", 1'b1, 32'h0, 1'b1, 32'hC0DEFFFC, 32'h0);
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        expect_all("wrap_next", 1'b1, 32'h4, 1'b1, 32'hC0DE0000, 32'h4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
